// File: rtl/decorr_sequencer_if.sv
// Handshake bundle between the decorrelator sequencer, its bit source and the lane array.
// The sequencer takes the slave side; the job controller/bench takes the master side.
interface decorr_sequencer_if #(
   parameter int WIDTH  = 5,
   parameter int NWIN_W = 8
);
   logic              start;
   logic [NWIN_W-1:0] num_windows;
   logic              hold;
   logic              in_ready;
   logic [WIDTH-1:0]  counter_sob;
   logic              enable;
   logic              out_valid;
   logic              busy;
   logic              done;
   logic [NWIN_W-1:0] win_cnt;

   modport master (
      output start, num_windows, hold,
      input  in_ready, counter_sob, enable, out_valid, busy, done, win_cnt
   );

   modport slave (
      input  start, num_windows, hold,
      output in_ready, counter_sob, enable, out_valid, busy, done, win_cnt
   );
endinterface

// File: rtl/decorr_sequencer.sv
// Window sequencer for the stochastic-bitstream decorrelator lanes: shared counter_sob,
// regeneration enable and FILL/RUN/DRAIN framing of an N-window job, all outputs registered.
module decorr_sequencer #(
   parameter int WIDTH  = 5,
   parameter int NWIN_W = 8
) (
   input  logic                clk,
   input  logic                rst,
   decorr_sequencer_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_RUN,
      S_DRAIN,
      S_FINISH
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  cnt_q, cnt_d;
   logic [NWIN_W-1:0] n_q, n_d;
   logic [NWIN_W-1:0] win_q, win_d;
   logic              in_ready_q, in_ready_d;
   logic              enable_q, enable_d;
   logic              out_valid_q, out_valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              seq_st;
   logic              frz;
   logic              wrap;
   logic [NWIN_W-1:0] win_inc;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      n_d      = n_q;
      win_d    = win_q;
      seq_st   = (state_q == S_FILL) || (state_q == S_RUN) || (state_q == S_DRAIN);
      frz      = seq_st && bus.hold;
      wrap     = seq_st && !bus.hold && (cnt_q == '1);
      win_inc  = win_q + NWIN_W'(1);

      if (seq_st && !bus.hold) begin
         cnt_d = cnt_q + WIDTH'(1);
      end

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (bus.start) begin
               n_d     = bus.num_windows;
               win_d   = '0;
               state_d = (bus.num_windows == '0) ? S_FINISH : S_FILL;
            end
         end
         // FILL and RUN differ only in enable; a wrap that completes window N moves to DRAIN.
         S_FILL, S_RUN: begin
            if (wrap) begin
               if (win_q != n_q) begin
                  win_d = win_inc;
               end
               state_d = (win_inc == n_q) ? S_DRAIN : S_RUN;
            end
         end
         S_DRAIN: begin
            if (wrap) begin
               state_d = S_FINISH;
            end
         end
         S_FINISH: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they line up with the registered state.
      in_ready_d  = ((state_d == S_FILL) || (state_d == S_RUN)) && !frz;
      enable_d    = ((state_d == S_RUN) || (state_d == S_DRAIN)) && !frz;
      out_valid_d = enable_q;
      busy_d      = (state_d != S_IDLE);
      done_d      = (state_d == S_FINISH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         n_q         <= '0;
         win_q       <= '0;
         in_ready_q  <= 1'b0;
         enable_q    <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         n_q         <= n_d;
         win_q       <= win_d;
         in_ready_q  <= in_ready_d;
         enable_q    <= enable_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.counter_sob = cnt_q;
   assign bus.enable      = enable_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.win_cnt     = win_q;

endmodule

// File: tb/tb_decorr_sequencer.sv
// Directed bench for decorr_sequencer (WIDTH=3): per-cycle expected outputs are derived from
// the job timing, queued at start, and popped against the DUT one cycle at a time.
module tb_decorr_sequencer;

   localparam int WIDTH  = 3;
   localparam int NWIN_W = 8;

   typedef struct packed {
      logic       ir;
      logic [2:0] cnt;
      logic       en;
      logic       ov;
      logic       busy;
      logic       done;
      logic [7:0] win;
   } rec_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   decorr_sequencer_if #(.WIDTH(WIDTH), .NWIN_W(NWIN_W)) bus ();

   decorr_sequencer #(.WIDTH(WIDTH), .NWIN_W(NWIN_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic rec_t sample();
      rec_t r;
      r.ir   = bus.in_ready;
      r.cnt  = bus.counter_sob;
      r.en   = bus.enable;
      r.ov   = bus.out_valid;
      r.busy = bus.busy;
      r.done = bus.done;
      r.win  = bus.win_cnt;
      return r;
   endfunction

   // Hold is driven during cycles hs..hs+hl-1 and therefore freezes edges hs+1..hs+hl.
   function automatic rec_t model(input int n, input int k, input int hs, input int hl);
      rec_t r;
      int   held;
      int   p;
      int   ph;
      int   tot;
      logic fro;
      r    = '0;
      fro  = (hl > 0) && (k >= hs + 1) && (k <= hs + hl);
      held = 0;
      if (hl > 0 && k > hs) held = (k - hs < hl) ? (k - hs) : hl;
      p = k - held;
      if (n == 0) begin
         if (p == 0) begin
            r.done = 1'b1;
            r.busy = 1'b1;
         end
         return r;
      end
      tot = (n + 1) * 8;
      if (p < tot) begin
         ph     = p / 8;
         r.cnt  = 3'(p % 8);
         r.ir   = (ph < n) && !fro;
         r.en   = (ph >= 1) && !fro;
         r.busy = 1'b1;
         r.win  = 8'(ph);
      end else if (p == tot) begin
         r.done = 1'b1;
         r.busy = 1'b1;
         r.win  = 8'(n);
      end else begin
         r.win  = 8'(n);
      end
      return r;
   endfunction

   // rc: cycle at which reset is applied (-1: none); rs: cycle at which start is re-asserted.
   task automatic run_job(input int n, input int hs, input int hl, input int rc, input int rs);
      rec_t q[$];
      rec_t e;
      rec_t o;
      logic prev_en;
      int   len;
      len     = (n == 0) ? 2 : (n + 1) * 8 + hl + 2;
      prev_en = 1'b0;
      for (int k = 0; k < len; k++) begin
         e       = model(n, k, hs, hl);
         e.ov    = prev_en;
         prev_en = e.en;
         q.push_back(e);
      end

      bus.start       = 1'b1;
      bus.num_windows = 8'(n);
      @(posedge clk);
      #1;
      bus.start       = 1'b0;
      bus.num_windows = 8'($urandom_range(0, 255));

      for (int k = 0; k < len; k++) begin
         if (k > 0) begin
            @(posedge clk);
            #1;
         end
         e = q.pop_front();
         o = sample();
         checks++;
         assert (o === e) else begin
            errors++;
            $error("FAIL job n=%0d cyc%0d obs ir=%b cnt=%0d en=%b ov=%b busy=%b done=%b win=%0d exp ir=%b cnt=%0d en=%b ov=%b busy=%b done=%b win=%0d",
                   n, k, o.ir, o.cnt, o.en, o.ov, o.busy, o.done, o.win,
                   e.ir, e.cnt, e.en, e.ov, e.busy, e.done, e.win);
         end
         if (k == rc) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            o = sample();
            checks++;
            assert (o === rec_t'(0)) else begin
               errors++;
               $error("FAIL midjob_reset n=%0d obs=%h exp=%h", n, o, rec_t'(0));
            end
            q.delete();
            break;
         end
         bus.hold  = (k >= hs) && (k < hs + hl);
         bus.start = (k == rs);
         if (k == rs) bus.num_windows = 8'd5;
      end
      bus.hold  = 1'b0;
      bus.start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      rec_t o;
      clk             = 1'b0;
      rst             = 1'b1;
      checks          = 0;
      errors          = 0;
      bus.start       = 1'b1;
      bus.num_windows = 8'd3;
      bus.hold        = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      o = sample();
      checks++;
      assert (o === rec_t'(0)) else begin
         errors++;
         $error("FAIL reset_state obs=%h exp=%h", o, rec_t'(0));
      end
      bus.start = 1'b0;
      rst       = 1'b0;
      @(posedge clk);
      #1;

      run_job(2, -1, 0, -1, -1);
      run_job(1, -1, 0, -1, -1);
      run_job(0, -1, 0, -1, -1);
      run_job(2, 13, 3, -1, -1);
      run_job(4, -1, 0, 11, -1);
      run_job(1, -1, 0, -1, -1);
      run_job(2, -1, 0, -1, 10);
      run_job(3, 2, 2, -1, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/decorr_sequencer.md
Name: decorr_sequencer

Overview:
Controller for the stochastic-bitstream decorrelator lanes. Generates the shared window sequence count (`counter_sob`) and the regeneration `enable`, and frames a job of N input windows into FILL/RUN/DRAIN phases. Drives any number of decorrelator lanes in parallel, because all lanes share one `counter_sob` and one `enable`. Gives upstream a bit-request strobe and gives downstream a valid flag and a done pulse.

Parameters:
- `WIDTH`, default 5: width of `counter_sob`; window length is 2^WIDTH cycles.
- `NWIN_W`, default 8: width of the window-count fields.

Ports:
- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: job request. Sampled only in IDLE.
- `num_windows`, input, NWIN_W: number of input windows in the job. Latched on start accept.
- `hold`, input, 1: pause. Freezes the sequence while high.
- `in_ready`, output, 1: upstream must present a valid stream bit this cycle.
- `counter_sob`, output, WIDTH: shared window sequence count to the lanes.
- `enable`, output, 1: regeneration enable to the lanes.
- `out_valid`, output, 1: lane `out1` is valid this cycle.
- `busy`, output, 1: high in any state other than IDLE.
- `done`, output, 1: one-cycle pulse at job end.
- `win_cnt`, output, NWIN_W: number of completed input windows.

Behaviour:
- All outputs are registered.
- rst=1: next edge gives state=IDLE and all outputs 0, including `counter_sob` and the latched N. This holds in every state, including mid-job.
- States: IDLE, FILL, RUN, DRAIN, FINISH.
- An "active cycle" is a cycle in FILL, RUN or DRAIN with hold=0. On an active edge, `counter_sob` increments modulo 2^WIDTH.
- hold=1 in FILL, RUN or DRAIN:
  - `counter_sob`, state and `win_cnt` are frozen.
  - `in_ready`=0 and `enable`=0.
  - Operation resumes exactly where it left off on release.
- hold is ignored in IDLE and FINISH.
- A window wrap is an active edge where `counter_sob` goes from 2^WIDTH-1 to 0.
- IDLE:
  - `counter_sob`=0.
  - start=1 with num_windows!=0: latch N=num_windows, `win_cnt`=0, go to FILL.
  - start=1 with num_windows==0: go to FINISH. No window is run.
- FILL:
  - `in_ready`=1, `enable`=0.
  - On wrap: `win_cnt`+1; if N==1 go to DRAIN, else go to RUN.
- RUN:
  - `in_ready`=1, `enable`=1.
  - On wrap: `win_cnt`+1; if `win_cnt`+1==N go to DRAIN, else stay in RUN.
- DRAIN:
  - `in_ready`=0, `enable`=1. This regenerates the last latched window.
  - On wrap: go to FINISH.
- FINISH:
  - Lasts exactly 1 cycle. `done`=1, `enable`=0, `in_ready`=0, `counter_sob` holds 0.
  - Next state is IDLE.
  - `win_cnt` holds its final value until the next start accept.
- `enable` is 1 only in RUN or DRAIN with hold=0.
- `out_valid` is `enable` delayed by one cycle, because the lane output is registered. This delay also applies across hold edges and across the FINISH transition.
- start while busy=1 is ignored, and num_windows changes while busy have no effect.
- Timing without hold, with start sampled at edge 0 and W=2^WIDTH:
  - FILL occupies edges 1..W.
  - RUN occupies the next (N-1)·W edges.
  - DRAIN occupies the next W edges.
  - `done` is high for the cycle after edge (N+1)·W.
- Each hold cycle adds 1 cycle to this timing.
- `win_cnt` saturates at N and never wraps within a job.

Test Plan (all with WIDTH=3, so W=8):
- start with N=2, no hold:
  - `in_ready`=1 for 16 cycles, then `enable`=1 for cycles 8..23 after accept.
  - `out_valid` for cycles 9..24; `done` pulses once at cycle 24.
  - `win_cnt` ends at 2; `counter_sob` sequence is 0..7,0..7,0..7,0.
- start with N=1: RUN is skipped; FILL lasts 8 cycles, DRAIN lasts 8 cycles, `done` pulses at cycle 16, `win_cnt`=1.
- start with N=0: `done` pulses the cycle after accept; `enable`, `in_ready` and `counter_sob` stay 0; `busy` is high for 1 cycle.
- N=2 with hold=1 for 3 cycles while `counter_sob`=5 in RUN:
  - `counter_sob` stays at 5, `enable`=0, and `out_valid` drops 1 cycle later.
  - `done` moves from cycle 24 to cycle 27.
- rst=1 at `counter_sob`=3 in RUN with N=4: next cycle all outputs are 0 and state is IDLE; a new start with N=1 then completes normally in 16 cycles.
- start re-asserted with N=5 during RUN of an N=2 job: ignored; the job finishes at cycle 24 with `win_cnt`=2.
